mux_scan_sequencer: RTL and testbench

Sequential controller that sits directly upstream of the 16:1 mux. It loads a 16-bit word onto the mux data inputs and steps the mux select through every index. It samples the mux output each step and presents the selected bits as a serial stream with a valid/ready handshake. It also reassembles the sampled bits into a captured word so the mux path can be checked end to end.

---
 rtl/mux_scan_pkg.sv | 28 ++
 rtl/mux_scan_sequencer_if.sv | 27 ++
 rtl/mux_scan_sequencer.sv | 124 ++++++++++++
 tb/tb_mux_scan_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// Optional feature macro used by the design: MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned N     = 2 ** SEL_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    DONE
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] first;
    logic [SEL_W-1:0] last;
  } sel_range_t;

  // First and last select index for the chosen scan order.
  function automatic sel_range_t sel_range(input bit msb_first);
    sel_range_t r;
    r.first = msb_first ? SEL_W'(N - 1) : '0;
    r.last  = msb_first ? '0 : SEL_W'(N - 1);
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Bus between the scan sequencer, the 16:1 mux and the serial consumer.
interface mux_scan_sequencer_if;
  import mux_scan_pkg::*;

  logic                start;
  logic [N-1:0]        din;
  logic [N-1:0]        mux_d;
  logic [SEL_W-1:0]    mux_s;
  logic                mux_y;
  logic                ser_bit;
  logic                ser_valid;
  logic                ser_ready;
  logic                busy;
  logic                done;
  logic [N-1:0]        cap_word;

  modport master (
    input  start, din, mux_y, ser_ready,
    output mux_d, mux_s, ser_bit, ser_valid, busy, done, cap_word
  );

  modport slave (
    output start, din, mux_y, ser_ready,
    input  mux_d, mux_s, ser_bit, ser_valid, busy, done, cap_word
  );

endinterface

// File: rtl/mux_scan_sequencer.sv
// Loads a word onto a 16:1 mux, walks the select, streams the mux output serially
// and reassembles it into cap_word. Define MUX_SCAN_PARITY_EN for a trailing parity beat.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  mux_scan_sequencer_if.master bus
);

  localparam sel_range_t C_RANGE = sel_range(MSB_FIRST);

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_mux_d, w_mux_d_nxt;
  logic [N-1:0]     r_cap, w_cap_nxt;
  logic [SEL_W-1:0] r_mux_s, w_mux_s_nxt;
  logic             r_ser_valid, w_ser_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_xfer;

  assign w_xfer = r_ser_valid && bus.ser_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and registered-output next values.
  always_comb begin
    w_state_nxt     = r_state;
    w_mux_d_nxt     = r_mux_d;
    w_mux_s_nxt     = r_mux_s;
    w_cap_nxt       = r_cap;
    w_ser_valid_nxt = r_ser_valid;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_mux_d_nxt     = bus.din;
          w_mux_s_nxt     = C_RANGE.first;
          w_cap_nxt       = '0;
          w_busy_nxt      = 1'b1;
          w_ser_valid_nxt = 1'b1;
          w_state_nxt     = SHIFT;
        end
      end
      SHIFT: begin
        if (w_xfer) begin
          w_cap_nxt[r_mux_s] = bus.mux_y;
          // Terminate on the last index so the counter never wraps.
          if (r_mux_s == C_RANGE.last) begin
`ifdef MUX_SCAN_PARITY_EN
            w_state_nxt     = PARITY;
`else
            w_state_nxt     = DONE;
            w_ser_valid_nxt = 1'b0;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b1;
`endif
          end else begin
            w_mux_s_nxt = MSB_FIRST ? r_mux_s - SEL_W'(1) : r_mux_s + SEL_W'(1);
          end
        end
      end
`ifdef MUX_SCAN_PARITY_EN
      PARITY: begin
        if (w_xfer) begin
          w_state_nxt     = DONE;
          w_ser_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
          w_done_nxt      = 1'b1;
        end
      end
`endif
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt     = IDLE;
        w_ser_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mux_d     <= '0;
      r_mux_s     <= '0;
      r_cap       <= '0;
      r_ser_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mux_d     <= w_mux_d_nxt;
      r_mux_s     <= w_mux_s_nxt;
      r_cap       <= w_cap_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign bus.mux_d     = r_mux_d;
  assign bus.mux_s     = r_mux_s;
  assign bus.cap_word  = r_cap;
  assign bus.ser_valid = r_ser_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

`ifdef MUX_SCAN_PARITY_EN
  // Even parity over the captured word replaces the mux output on the last beat.
  assign bus.ser_bit = (r_state == PARITY) ? ^r_cap : bus.mux_y;
`else
  assign bus.ser_bit = bus.mux_y;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench: LSB-first and MSB-first sequencers run in lockstep behind a 16:1 mux.
module tb_mux_scan_sequencer;
  import mux_scan_pkg::*;

`ifdef MUX_SCAN_PARITY_EN
  localparam int TOTAL = int'(N) + 1;
`else
  localparam int TOTAL = int'(N);
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tb_start = 1'b0;
  logic [N-1:0]  tb_din = '0;
  logic          tb_ready = 1'b0;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  mux_scan_sequencer_if if0 ();
  mux_scan_sequencer_if if1 ();

  assign if0.start     = tb_start;
  assign if0.din       = tb_din;
  assign if0.ser_ready = tb_ready;
  assign if0.mux_y     = if0.mux_d[if0.mux_s];
  assign if1.start     = tb_start;
  assign if1.din       = tb_din;
  assign if1.ser_ready = tb_ready;
  assign if1.mux_y     = if1.mux_d[if1.mux_s];

  mux_scan_sequencer #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mux_scan_sequencer #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct {
    logic [15:0] din;
    int          mode;
    bit          inject;
    logic [15:0] exp_cap;
    logic        exp_par;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy0"},  32'(if0.busy), 0);
    chk({tag, "_valid0"}, 32'(if0.ser_valid), 0);
    chk({tag, "_done0"},  32'(if0.done), 0);
    chk({tag, "_busy1"},  32'(if1.busy), 0);
    chk({tag, "_valid1"}, 32'(if1.ser_valid), 0);
    chk({tag, "_done1"},  32'(if1.done), 0);
  endtask

  // One full scan; expected beats come from din bit order, parity from the record.
  task automatic run_scan(input vec_t v);
    logic q0[$];
    logic q1[$];
    int   beat = 0;
    int   cyc  = 0;
    bit   finished = 0;
    for (int i = 0; i < int'(N); i++) begin
      q0.push_back(v.din[i]);
      q1.push_back(v.din[int'(N) - 1 - i]);
    end
    q0.push_back(v.exp_par);
    q1.push_back(v.exp_par);

    @(posedge clk); #1;
    tb_start = 1'b1; tb_din = v.din; tb_ready = ready_for(v.mode, 0);
    @(posedge clk); #1;
    tb_start = 1'b0; tb_din = 16'($urandom);
    while (cyc < 200) begin
      @(negedge clk);
      if (beat == TOTAL) begin
        chk("done0", 32'(if0.done), 1);
        chk("done1", 32'(if1.done), 1);
        chk("done_busy0", 32'(if0.busy), 0);
        chk("done_valid0", 32'(if0.ser_valid), 0);
        chk("cap0", 32'(if0.cap_word), 32'(v.exp_cap));
        chk("cap1", 32'(if1.cap_word), 32'(v.exp_cap));
        if (v.mode == 0) chk("latency", 32'(cyc), 32'(TOTAL));
        finished = 1;
        break;
      end
      chk("valid0", 32'(if0.ser_valid), 1);
      chk("valid1", 32'(if1.ser_valid), 1);
      chk("busy0", 32'(if0.busy), 1);
      chk("early_done", 32'(if0.done | if1.done), 0);
      chk("mux_d0", 32'(if0.mux_d), 32'(v.din));
      chk("mux_d1", 32'(if1.mux_d), 32'(v.din));
      if (beat < int'(N)) begin
        chk("mux_s0", 32'(if0.mux_s), 32'(beat));
        chk("mux_s1", 32'(if1.mux_s), 32'(int'(N) - 1 - beat));
      end
      chk("ser_bit0", 32'(if0.ser_bit), 32'(q0[beat]));
      chk("ser_bit1", 32'(if1.ser_bit), 32'(q1[beat]));
      if (tb_ready) beat++;
      @(posedge clk); #1;
      cyc++;
      tb_ready = ready_for(v.mode, cyc);
      tb_start = v.inject && (beat == 5 || beat == TOTAL);
    end
    if (!finished) chk("scan_timeout", 32'(beat), 32'(TOTAL));
    @(posedge clk); #1;
    tb_start = 1'b0;
    @(negedge clk);
    chk_idle("after_done");
    chk("cap_hold0", 32'(if0.cap_word), 32'(v.exp_cap));
    repeat (2) @(negedge clk);
    chk_idle("no_requeue");
  endtask

  task automatic reset_mid_scan();
    @(posedge clk); #1;
    tb_start = 1'b1; tb_din = 16'h3C5A; tb_ready = 1'b1;
    @(posedge clk); #1;
    tb_start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    chk("pre_rst_busy", 32'(if0.busy), 1);
    chk("pre_rst_mux_s", 32'(if0.mux_s), 8);
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("rst_mux_d0", 32'(if0.mux_d), 0);
    chk("rst_mux_s0", 32'(if0.mux_s), 0);
    chk("rst_mux_s1", 32'(if1.mux_s), 0);
    chk("rst_cap0", 32'(if0.cap_word), 0);
    chk("rst_cap1", 32'(if1.cap_word), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_idle("post_rst");
    chk("post_rst_mux_s0", 32'(if0.mux_s), 0);
  endtask

  initial begin
    vec_t vecs[4];
    vecs[0] = '{din: 16'hA5C3, mode: 0, inject: 1'b0, exp_cap: 16'hA5C3, exp_par: 1'b0};
    vecs[1] = '{din: 16'hFFFF, mode: 1, inject: 1'b0, exp_cap: 16'hFFFF, exp_par: 1'b0};
    vecs[2] = '{din: 16'h0001, mode: 0, inject: 1'b1, exp_cap: 16'h0001, exp_par: 1'b1};
    vecs[3] = '{din: 16'h8000, mode: 1, inject: 1'b1, exp_cap: 16'h8000, exp_par: 1'b1};

    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_mux_d", 32'(if0.mux_d), 0);
    chk("reset_cap", 32'(if1.cap_word), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("idle_hold");

    for (int i = 0; i < 4; i++) run_scan(vecs[i]);

    reset_mid_scan();

    for (int r = 0; r < 6; r++) begin
      vec_t rv;
      rv.din     = 16'($urandom);
      rv.mode    = 2;
      rv.inject  = 1'(r % 2);
      rv.exp_cap = rv.din;
      rv.exp_par = ^rv.din;
      run_scan(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
